// File: rtl/multitap_sms_reader.sv
// Console-side reader for the SMS-style 4-player multitap: walks the device index with TH,
// samples each pad's active-low lines and publishes all four pads together once per frame.
module multitap_sms_reader #(
  parameter int unsigned SYNC_CYCLES   = 900000,
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned PHASE_CYCLES  = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [6:0] port_in,
  output logic [6:0] port_out,
  output logic [6:0] port_dir,
  output logic [5:0] pad1,
  output logic [5:0] pad2,
  output logic [5:0] pad3,
  output logic [5:0] pad4,
  output logic       frame_done,
  output logic       busy
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSync   = 2'd1;
  localparam logic [1:0] StSettle = 2'd2;
  localparam logic [1:0] StHigh   = 2'd3;

  localparam logic [23:0] SyncLast   = 24'(SYNC_CYCLES - 1);
  localparam logic [23:0] SettleLast = 24'(SETTLE_CYCLES - 1);
  localparam logic [23:0] PhaseLast  = 24'(PHASE_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [23:0]      cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             th_q, th_d;
  logic [3:0][5:0]  shadow_q, shadow_d;
  logic [3:0][5:0]  pad_q, pad_d;
  logic             frame_done_q, frame_done_d;

  // TH readback is not needed: the device index is tracked purely from what we drive.
  logic unused_th_readback;
  assign unused_th_readback = port_in[6];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 24'd1;
    idx_d        = idx_q;
    th_d         = th_q;
    shadow_d     = shadow_q;
    pad_d        = pad_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        th_d  = 1'b1;
        cnt_d = '0;
        if (enable) begin
          state_d = StSync;
        end
      end
      StSync: begin
        th_d = 1'b1;
        if (cnt_q == SyncLast) begin
          state_d = StSettle;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end
      end
      StSettle: begin
        if (cnt_q == SettleLast) begin
          shadow_d[idx_q] = ~port_in[5:0];
          cnt_d           = '0;
          th_d            = 1'b1;
          if (idx_q != 2'd3) begin
            state_d = StHigh;
          end else begin
            // Commit includes the pad sampled this very cycle.
            pad_d        = shadow_d;
            frame_done_d = 1'b1;
            state_d      = enable ? StSync : StIdle;
          end
        end
      end
      StHigh: begin
        th_d = 1'b1;
        if (cnt_q == PhaseLast) begin
          // Falling edge lands together with SETTLE entry.
          th_d    = 1'b0;
          idx_d   = idx_q + 2'd1;
          state_d = StSettle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      th_q         <= 1'b1;
      shadow_q     <= '0;
      pad_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      th_q         <= th_d;
      shadow_q     <= shadow_d;
      pad_q        <= pad_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign port_out   = {th_q, 6'h3F};
  assign port_dir   = 7'b0111111;
  assign pad1       = pad_q[0];
  assign pad2       = pad_q[1];
  assign pad3       = pad_q[2];
  assign pad4       = pad_q[3];
  assign frame_done = frame_done_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_multitap_sms_reader.sv
// Bench for multitap_sms_reader: behavioural multitap device plus a frame scoreboard.
// Timing is scaled down so the run stays short; device timeout sits between the sync and
// the per-pad high time, as on real hardware.
module tb_multitap_sms_reader;

  localparam int unsigned SYNC    = 2000;
  localparam int unsigned SETTLE  = 8;
  localparam int unsigned PHASE   = 32;
  localparam int unsigned TIMEOUT = 1900;
  localparam int unsigned FRAME   = SYNC + 4 * SETTLE + 3 * PHASE;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [6:0] port_in;
  logic [6:0] port_out;
  logic [6:0] port_dir;
  logic [5:0] pad1, pad2, pad3, pad4;
  logic       frame_done;
  logic       busy;

  always #5 clk = ~clk;

  multitap_sms_reader #(
    .SYNC_CYCLES  (SYNC),
    .SETTLE_CYCLES(SETTLE),
    .PHASE_CYCLES (PHASE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .port_in   (port_in),
    .port_out  (port_out),
    .port_dir  (port_dir),
    .pad1      (pad1),
    .pad2      (pad2),
    .pad3      (pad3),
    .pad4      (pad4),
    .frame_done(frame_done),
    .busy      (busy)
  );

  // Device model: long TH-high resets index, each TH fall advances it.
  logic [5:0] dev_pad [4];
  logic [1:0] dev_idx = 2'd0;
  int         hi_cnt = 0;
  logic       th_prev = 1'b1;
  logic       dev_force = 1'b0;

  always @(posedge clk) begin
    if (dev_force) begin
      dev_idx <= 2'd2;
      hi_cnt  <= 0;
      th_prev <= 1'b1;
    end else begin
      th_prev <= port_out[6];
      if (port_out[6] === 1'b1) begin
        if (hi_cnt < TIMEOUT) hi_cnt <= hi_cnt + 1;
        else dev_idx <= 2'd0;
      end else begin
        hi_cnt <= 0;
      end
      if (th_prev === 1'b1 && port_out[6] === 1'b0) dev_idx <= dev_idx + 2'd1;
    end
  end

  assign port_in = {port_out[6], ~dev_pad[dev_idx]};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [5:0] p1;
    logic [5:0] p2;
    logic [5:0] p3;
    logic [5:0] p4;
  } frame_t;

  frame_t exp_q[$];
  int     errors = 0;
  int     checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every frame_done pops one expected frame.
  initial begin
    frame_t e;
    forever begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame_done: got frame_done=1 expected none at cycle %0d", cyc);
        end else begin
          e = exp_q.pop_front();
          check("pad1", 32'(pad1), 32'(e.p1));
          check("pad2", 32'(pad2), 32'(e.p2));
          check("pad3", 32'(pad3), 32'(e.p3));
          check("pad4", 32'(pad4), 32'(e.p4));
        end
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 3 * FRAME);
    if (frame_done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s: got no frame_done expected one within %0d cycles", name, 3 * FRAME);
    end
  endtask

  task automatic wait_falls(input int want, input string name);
    int   seen = 0;
    int   n = 0;
    logic prev = port_out[6];
    while (seen < want && n < 3 * FRAME) begin
      @(negedge clk);
      n++;
      if (prev === 1'b1 && port_out[6] === 1'b0) seen++;
      prev = port_out[6];
    end
    check(name, 32'(seen), 32'(want));
  endtask

  initial begin
    int   f[$];
    int   r[$];
    int   done_n;
    int   falls_first;
    int   extra_done;
    int   th_low;
    logic prev_th;
    int   n;

    dev_pad[0] = 6'h01;  // P1 UP
    dev_pad[1] = 6'h10;  // P2 A
    dev_pad[2] = 6'h24;  // P3 LEFT+B
    dev_pad[3] = 6'h00;

    tick(3);
    reset = 1'b0;
    tick(2);
    check("rst_port_out", 32'(port_out), 32'h7F);
    check("rst_port_dir", 32'(port_dir), 32'h3F);
    check("rst_pads", 32'({pad1, pad2, pad3, pad4}), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_frame_done", 32'(frame_done), 32'h0);

    // Distinct pads and TH waveform over two back-to-back frames.
    exp_q.push_back({6'h01, 6'h10, 6'h24, 6'h00});
    exp_q.push_back({6'h01, 6'h10, 6'h24, 6'h00});
    enable      = 1'b1;
    done_n      = 0;
    falls_first = -1;
    prev_th     = 1'b1;
    for (int i = 0; i < 3 * FRAME && done_n < 2; i++) begin
      @(negedge clk);
      if (prev_th === 1'b1 && port_out[6] === 1'b0) f.push_back(cyc);
      if (prev_th === 1'b0 && port_out[6] === 1'b1) r.push_back(cyc);
      prev_th = port_out[6];
      if (frame_done === 1'b1) begin
        done_n++;
        if (done_n == 1) falls_first = f.size();
      end
    end
    check("frames_seen", 32'(done_n), 32'd2);
    check("falls_per_frame", 32'(falls_first), 32'd3);
    check("edge_count_ok", 32'(f.size() >= 4 && r.size() >= 3), 32'd1);
    if (f.size() >= 4 && r.size() >= 3) begin
      check("low_width0", 32'(r[0] - f[0]), 32'(SETTLE));
      check("high_width0", 32'(f[1] - r[0]), 32'(PHASE));
      check("low_width1", 32'(r[1] - f[1]), 32'(SETTLE));
      check("high_width1", 32'(f[2] - r[1]), 32'(PHASE));
      check("low_width2", 32'(r[2] - f[2]), 32'(SETTLE));
      check("frame_len", 32'(f[3] - f[0]), 32'(FRAME));
    end

    // P2 changes after its sample: old value this frame, new value next frame.
    exp_q.push_back({6'h01, 6'h10, 6'h24, 6'h00});
    exp_q.push_back({6'h01, 6'h08, 6'h24, 6'h00});
    wait_falls(2, "p2_change_point");
    dev_pad[1] = 6'h08;
    wait_done("frame_old_p2");
    wait_done("frame_new_p2");

    // enable dropped mid-frame: this frame still commits, then IDLE.
    enable = 1'b0;
    exp_q.push_back({6'h01, 6'h08, 6'h24, 6'h00});
    wait_done("frame_after_disable");
    tick(2);
    check("disable_busy", 32'(busy), 32'h0);
    check("disable_th", 32'(port_out), 32'h7F);

    // Resync from a misaligned device, with a one-cycle enable pulse.
    dev_force = 1'b1;
    tick(1);
    dev_force = 1'b0;
    exp_q.push_back({6'h01, 6'h08, 6'h24, 6'h00});
    enable = 1'b1;
    tick(1);
    enable = 1'b0;
    wait_done("pulse_frame");
    extra_done = 0;
    th_low     = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (frame_done !== 1'b0) extra_done++;
      if (port_out[6] !== 1'b1) th_low++;
    end
    check("pulse_extra_done", 32'(extra_done), 32'd0);
    check("pulse_th_low", 32'(th_low), 32'd0);
    check("pulse_busy", 32'(busy), 32'h0);

    // Reset during the HIGH phase after pad 2's sample.
    enable = 1'b1;
    wait_falls(1, "reset_point_fall");
    n = 0;
    while (port_out[6] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reset_point_rise", 32'(port_out[6]), 32'h1);
    tick(10);
    reset  = 1'b1;
    enable = 1'b0;
    tick(1);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_port_out", 32'(port_out), 32'h7F);
    check("midrst_pads", 32'({pad1, pad2, pad3, pad4}), 32'h0);
    check("midrst_frame_done", 32'(frame_done), 32'h0);
    reset = 1'b0;
    extra_done = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (frame_done !== 1'b0) extra_done++;
    end
    check("midrst_no_done", 32'(extra_done), 32'd0);
    check("midrst_pads_hold", 32'({pad1, pad2, pad3, pad4}), 32'h0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
